// File: rtl/updown_mod_counter.sv
// updown_mod_counter: parametrised up/down modulo counter.
// Counts modulo MAX_VAL+1 with synchronous load (clamped to MAX_VAL),
// synchronous clear, and either wrap or saturate behaviour at the limits.
// tc is combinational so a chain of stages can be built by driving the
// next stage's en from this stage's tc. wrap is a one-cycle registered
// pulse after a wrap; ovf is a sticky flag set by any limit event.
module updown_mod_counter #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic             at_limit;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] wrap_val;

    // Limit detection, clamped load value and next count candidates.
    // NOTE: every signal gets a value on every path through always_comb, so no latch is inferred.
    always_comb begin
        at_limit = up ? (out == LIMIT) : (out == '0);
        load_val = (data > LIMIT) ? LIMIT : data;
        step_val = up ? (out + ONE) : (out - ONE);
        wrap_val = up ? '0 : LIMIT;
    end

    // Terminal count depends only on en, up and the current count, never on ld or clr.
    assign tc = en & at_limit;

    // Count register and flags; priority is reset, clr, ld, then en.
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            out  <= '0;
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else if (clr) begin
            out  <= '0;
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else if (ld) begin
            // A load always wins over counting and leaves the sticky flag alone.
            out  <= load_val;
            wrap <= 1'b0;
        end else if (en) begin
            if (!at_limit) begin
                out  <= step_val;
                wrap <= 1'b0;
            end else if (SATURATE) begin
                wrap <= 1'b0;
                ovf  <= 1'b1;
            end else begin
                out  <= wrap_val;
                wrap <= 1'b1;
                ovf  <= 1'b1;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised up/down modulo counter with synchronous load, synchronous clear and selectable wrap or saturate behaviour at the count limits.
- Provides a combinational terminal-count output for cascading stages (tc of one stage drives en of the next), plus registered wrap and sticky overflow flags.
- Serves as the general-purpose counter primitive for datapath index, loop and timeout counting, replacing fixed-width 3-bit up counters.

Parameters:
WIDTH, 8, counter width in bits (>=2).
MAX_VAL, 2**WIDTH-1, highest count value (modulus = MAX_VAL+1), 1 <= MAX_VAL <= 2**WIDTH-1.
SATURATE, 0, 0 = wrap at limits, 1 = hold at limits.

Ports:
clk  input  1  clock, all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
clr  input  1  synchronous clear of count and flags.
ld  input  1  load data into count.
data  input  WIDTH  load value.
en  input  1  count enable.
up  input  1  direction: 1 = increment, 0 = decrement.
out  output  WIDTH  registered count value.
tc  output  1  combinational terminal count = en & at_limit.
wrap  output  1  registered pulse, high for one cycle after a wrap.
ovf  output  1  registered sticky flag, set on any limit event.

Behaviour:
- Reset value: out=0, wrap=0, ovf=0. Reset mid-count takes effect on the next edge, with no other action that cycle.
- Priority per edge: reset > clr > ld > en. Lower-priority inputs are ignored that cycle.
- clr: out<=0, wrap<=0, ovf<=0.
- ld: out<=min(data, MAX_VAL), so out-of-range loads clamp to MAX_VAL. wrap<=0 and ovf is unchanged. en is ignored in a load cycle.
- at_limit = up ? (out==MAX_VAL) : (out==0). This is a combinational function of the current out and up.
- tc = en & at_limit. It is purely combinational with no clock latency, and depends only on en, up and out, never on ld or clr. It is asserted in the same cycle as the limit event.
- en=1, not at_limit: out<=out+1 if up, otherwise out<=out-1. wrap<=0.
- en=1, at_limit, SATURATE=0:
  - Counting up, out<=0; counting down, out<=MAX_VAL.
  - wrap<=1 and ovf<=1.
- en=1, at_limit, SATURATE=1: out holds, wrap<=0, ovf<=1.
- en=0: out holds, wrap<=0, ovf holds.
- Arithmetic is WIDTH bits. out never exceeds MAX_VAL under any input sequence.
- A direction change takes effect on the same edge as en. There is no pipeline, so count latency is 1 cycle from en to the out change.
- MAX_VAL=1 is legal: the counter toggles 0/1 in wrap mode.

Test Plan:
- WIDTH=4, MAX_VAL=9, SATURATE=0:
  - Reset, then en=1, up=1 for 12 cycles -> out 0,1..9,0,1.
  - tc high only while out=9.
  - wrap high the cycle out=0 after 9.
  - ovf set from that cycle onward.
- Same config, ld=1, data=3, then en=1, up=0 for 5 cycles -> out 3,2,1,0,9,8.
  - tc high while out=0.
  - wrap pulse one cycle when out=9.
- SATURATE=1, MAX_VAL=9:
  - ld data=8, en=1, up=1 for 3 cycles -> out 8,9,9,9 and ovf=1, wrap stays 0.
  - Then up=0 -> out 8.
- Out-of-range load: ld data=15 -> out=9.
  - In the same cycle as ld, with en=1 -> the load wins and there is no increment.
- Simultaneous events:
  - clr=1 with ld=1, en=1 at out=9 -> out=0, ovf=0, wrap=0.
  - reset asserted mid-count at out=5 with en=1 -> next edge out=0 and flags cleared.
- Cascade: two instances (WIDTH=4, MAX_VAL=9), with low.tc driving high.en and both up=1, run 100 cycles from reset -> {high,low} reads BCD 00..99 then 00.
  - high.tc at 99 with low.tc.
